im_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer placed in front of the instruction memory (IM) of the RV32I core.
- Owns the PC and drives the IM word address; the IM returns `rd` combinationally in the same cycle.
- Captures each fetched word with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects, start/pause, misaligned-target faults, and end-of-ROM halt.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_buf2.sv | 59 +++++
 rtl/im_fetch_ctrl.sv | 105 ++++++++++
 tb/tb_im_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State encoding, buffer entry layout and default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          BUF_DEPTH    = 2;
  localparam int          CNT_W        = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry shift FIFO of {pc, instr}; entry 0 is always the head.
// The head register is only rewritten on a real advance, so it holds when empty.
module fetch_buf2
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_ent_t       din_i,
  output fetch_ent_t       head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_ent_t       e0_q, e1_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i &&
                   ((cnt_q < CNT_W'(BUF_DEPTH)) || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!flush_i) begin
        if (pop_ok && cnt_q == CNT_W'(2)) begin
          e0_q <= e1_q;
        end
        // New data lands at the head only if the head slot is free after pop
        if (push_ok) begin
          if (cnt_q == '0 || (cnt_q == CNT_W'(1) && pop_ok)) begin
            e0_q <= din_i;
          end else begin
            e1_q <= din_i;
          end
        end
      end
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM address and
// feeds decode through a 2-entry buffer with redirect/halt handling.
module im_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          AW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic [AW-1:0] im_addr,
  input  logic [31:0]   im_rd,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  input  logic          instr_ready,
  output logic          halted,
  output logic          misalign
);

  localparam logic [31:0] END_PC = 32'(DEPTH * 4);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic             mis_q;
  logic [CNT_W-1:0] count;
  fetch_ent_t       head;
  fetch_ent_t       din;
  logic             in_range;
  logic             tgt_aligned;
  logic             tgt_in_range;
  logic             pop;
  logic             push;

  assign in_range     = pc_q < END_PC;
  assign tgt_aligned  = redirect_pc[1:0] == 2'b00;
  assign tgt_in_range = redirect_pc < END_PC;

  assign instr_valid = count != '0;
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state_q == FETCH) && in_range && !redirect_valid &&
                ((count < CNT_W'(BUF_DEPTH)) || pop);

  assign din.pc    = pc_q;
  assign din.instr = im_rd;

  fetch_buf2 u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (din),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else if (redirect_valid) begin
      if (tgt_aligned) begin
        pc_q <= redirect_pc;
        if (tgt_in_range) begin
          state_q <= en ? FETCH : IDLE;
          mis_q   <= 1'b0;
        end else begin
          state_q <= HALT;
        end
      end else begin
        state_q <= HALT;
        mis_q   <= 1'b1;
      end
    end else begin
      if (push) begin
        pc_q <= pc_q + 32'd4;
      end
      unique case (state_q)
        IDLE:    if (en) state_q <= FETCH;
        FETCH: begin
          if (!in_range) begin
            state_q <= HALT;
          end else if (!en) begin
            state_q <= IDLE;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign im_addr  = pc_q[AW+1:2];
  assign instr    = head.instr;
  assign instr_pc = head.pc;
  assign halted   = state_q == HALT;
  assign misalign = mis_q;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: queue-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_im_fetch_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_rd;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;
  logic          halted;
  logic          misalign;

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  assign im_rd = (im_addr < AW'(DEPTH)) ? mem[im_addr[5:0]] : 32'h0;

  im_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_rd          (im_rd),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .misalign       (misalign)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle 1=fetch 2=halt; buffer is a queue of {pc,instr}
  logic [31:0] m_pc;
  int          m_st;
  logic        m_mis;
  logic [63:0] m_q [$];
  logic [63:0] m_last;

  always @(posedge clk) begin
    bit pop, push, inr;
    if (rst) begin
      m_pc = 32'h0; m_st = 0; m_mis = 0;
      m_q.delete(); m_last = 64'h0;
    end else if (redirect_valid) begin
      m_q.delete();
      if (redirect_pc % 4 == 0) begin
        m_pc = redirect_pc;
        if (redirect_pc < DEPTH * 4) begin
          m_st = en ? 1 : 0; m_mis = 0;
        end else begin
          m_st = 2;
        end
      end else begin
        m_st = 2; m_mis = 1;
      end
    end else begin
      inr  = m_pc < DEPTH * 4;
      pop  = (m_q.size() > 0) && instr_ready;
      push = (m_st == 1) && inr && (m_q.size() < 2 || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, mem[m_pc / 4]});
        m_pc = m_pc + 4;
      end
      if (m_st == 0 && en) m_st = 1;
      else if (m_st == 1 && !inr) m_st = 2;
      else if (m_st == 1 && !en) m_st = 0;
    end
    if (m_q.size() > 0) m_last = m_q[0];
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", 32'(instr_valid), 32'(m_q.size() > 0));
      check("halted", 32'(halted), 32'(m_st == 2));
      check("misalign", 32'(misalign), 32'(m_mis));
      check("im_addr", 32'(im_addr), 32'(m_pc[AW+1:2]));
      check("instr", instr, m_last[31:0]);
      check("instr_pc", instr_pc, m_last[63:32]);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0]  = 32'h0030_0413;
    mem[1]  = 32'h0010_0493;
    mem[13] = 32'h0122_8463;
    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    @(negedge clk);
    tick();
    chk_on = 1;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_halt", 32'(halted), 32'h0);
    check("rst_addr", 32'(im_addr), 32'h0);

    // start-up
    rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
    tick(2);
    check("su_v0", 32'(instr_valid), 32'h1);
    check("su_i0", instr, 32'h0030_0413);
    check("su_p0", instr_pc, 32'h0);
    tick();
    check("su_i1", instr, 32'h0010_0493);
    check("su_p1", instr_pc, 32'h4);

    // backpressure
    do_reset();
    instr_ready = 1'b0;
    tick(6);
    check("bp_addr", 32'(im_addr), 32'h2);
    check("bp_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    check("bp_h4", instr_pc, 32'h4);
    tick();
    check("bp_h8", instr_pc, 32'h8);

    // redirect while full
    instr_ready = 1'b0;
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 32'h34;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush", 32'(instr_valid), 32'h0);
    tick();
    check("rd_valid", 32'(instr_valid), 32'h1);
    check("rd_instr", instr, 32'h0122_8463);
    check("rd_pc", instr_pc, 32'h34);

    // misaligned redirect then recovery
    redirect_valid = 1'b1; redirect_pc = 32'h36;
    tick();
    redirect_valid = 1'b0;
    check("mis_halt", 32'(halted), 32'h1);
    check("mis_flag", 32'(misalign), 32'h1);
    tick(3);
    check("mis_nopush", 32'(instr_valid), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("rec_halt", 32'(halted), 32'h0);
    check("rec_flag", 32'(misalign), 32'h0);
    instr_ready = 1'b1;
    tick();
    check("rec_pc", instr_pc, 32'h0);

    // end of ROM
    tick(80);
    check("eor_halt", 32'(halted), 32'h1);
    check("eor_valid", 32'(instr_valid), 32'h0);
    check("eor_pc", instr_pc, 32'hFC);

    // reset with redirect and full buffer
    redirect_valid = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick(4);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    check("rr_valid", 32'(instr_valid), 32'h0);
    check("rr_instr", instr, 32'h0);
    check("rr_pc", instr_pc, 32'h0);
    check("rr_addr", 32'(im_addr), 32'h0);

    // push and pop together while full
    tick(5);
    instr_ready = 1'b1;
    tick();
    check("pp_h4", instr_pc, 32'h4);
    tick();
    check("pp_h8", instr_pc, 32'h8);
    check("pp_valid", 32'(instr_valid), 32'h1);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      en          = $urandom_range(0, 9) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      rst         = $urandom_range(0, 199) == 0;
      redirect_valid = $urandom_range(0, 24) == 0;
      case ($urandom_range(0, 3))
        0, 1: redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 4;
        2: redirect_pc = 32'($urandom_range(0, DEPTH - 1)) * 4
                         + 32'($urandom_range(1, 3));
        default: redirect_pc = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC
                     : 32'h100 + 32'($urandom_range(0, 15)) * 4;
      endcase
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    tick();
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
